fft4_frame_loader: RTL and testbench
====================================

# fft4_frame_loader

Serial-to-parallel front end for the 4-point FFT core. Accepts one complex sample per cycle over a valid/ready stream and assembles 4-sample frames in a ping-pong buffer. Presents each complete frame on the eight parallel `in*` ports of `fft4`, with an output valid/ready handshake whose accept strobe drives `fft4.en`. Also re-aligns frames on a start-of-frame marker and counts dropped partial frames.

## Interface
- `DATA_WIDTH`, 8: signed width of each real and imaginary component, input and output.
- `CNT_WIDTH`, 8: width of the dropped-frame counter.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `s_valid`  in  1: input sample valid.
- `s_ready`  out  1: loader can accept a sample.
- `s_real`, `s_imag`  in  DATA_WIDTH: signed input sample.
- `s_sof`  in  1: sample is frame index 0; qualified by `s_valid && s_ready`.
- `out0_real` … `out3_real`, `out0_imag` … `out3_imag`  out  DATA_WIDTH: frame samples 0..3, in arrival order.
- `out_valid`  out  1: parallel frame valid.
- `out_ready`  in  1: consumer accepts the frame. Top level ties `fft4.en = out_valid & out_ready`.
- `drop_pulse`  out  1: one-cycle pulse when a partial frame is discarded.
- `drop_count`  out  CNT_WIDTH: saturating count of discarded partial frames.

## Operation
- **Storage:** two banks of 4 complex samples, each with a `full` flag.
  - Write side state: `wr_bank` and `wr_idx` (0..3).
  - Read side state: `rd_bank`.
- **Input handshake:**
  - `s_ready = !rst && !full[wr_bank]`. This is registered state only, with no combinational path from `out_ready`.
  - A sample is accepted when `s_valid && s_ready`. It is written to `bank[wr_bank][wr_idx]`.
- **Frame completion:** on an accept with `wr_idx == 3`:
  - set `full[wr_bank]`;
  - toggle `wr_bank`;
  - set `wr_idx` to 0.
- **Re-alignment:** on an accept with `s_sof = 1` and `wr_idx != 0`:
  - the partial frame is discarded;
  - the sample is written at index 0 and `wr_idx` becomes 1;
  - `drop_pulse` is asserted for the next cycle;
  - `drop_count` increments and saturates at all-ones.
- **Ignored markers:**
  - `s_sof` with `wr_idx == 0` is a normal accept.
  - `s_sof` is ignored when no sample is accepted.
- **Output side:**
  - `out_valid = full[rd_bank]`.
  - The `out*` ports reflect `bank[rd_bank]` contents directly from registers.
  - On `out_valid && out_ready`: clear `full[rd_bank]` and toggle `rd_bank`.
- **Simultaneous events:** a fill of one bank and a drain of the other in the same cycle are independent and both take effect.
- **Both banks full:** `s_ready` is low. A drain in cycle N raises `s_ready` in cycle N+1.
- **Arithmetic:** none on the data path. Samples pass bit-exact.
- **Reset:** reset mid-frame discards all buffered data. No partial frame is ever emitted.

## Timing
- **Reset values:**
  - `out_valid` = 0, `s_ready` = 0 while `rst` is high;
  - all `out*` data = 0;
  - `drop_pulse` = 0, `drop_count` = 0;
  - internal `wr_idx` = 0, `wr_bank` = 0, `rd_bank` = 0, both `full` = 0.
- **After reset:** `s_ready` is 1 in the first cycle after `rst` deasserts.
- **Latency:** 4th sample accepted at edge N → `out_valid` high and data stable after edge N, so it is visible in cycle N+1.
- **Throughput:** with `out_ready` held high, sustains 1 sample/cycle indefinitely, i.e. one frame per 4 cycles.
- **Output stability:** while `out_valid && !out_ready`, the `out*` data and `out_valid` hold stable.

## Structure
- **Shared package `fft4_pkg`:**
  - `FRAME_LEN = 4`;
  - default `DATA_WIDTH`;
  - `typedef struct` `cplx_t` {real, imag}.
  - Reused by `fft4` and later stages.
- **Sub-module `fft4_frame_bank`:** 4 × `cplx_t` registers, `full` flag, write/set/clear ports. Instantiated twice. The top holds the pointers, handshake logic and drop counter.

## Test plan
- **Single frame:** after reset, stream (1,0),(2,0),(-1,0),(3,0) with `out_ready` = 1.
  - `out_valid` pulses 1 cycle, one cycle after the 4th accept.
  - `out0..3_real` = 1, 2, -1, 3; imag = 0.
- **Back-pressure:** `out_ready` = 0, stream 12 samples continuously.
  - `s_ready` drops after the 8th accept.
  - Raising `out_ready` yields frames 1 then 2 in order.
  - `s_ready` returns the cycle after the first drain.
- **Re-alignment:** send 2 samples, then `s_sof` with (7,-7) followed by 3 samples.
  - `drop_pulse` pulses once and `drop_count` = 1.
  - Emitted frame starts with `out0` = (7,-7).
- **Saturation:** 300 forced re-alignments with `CNT_WIDTH` = 8 → `drop_count` = 255.
- **Reset mid-frame:** assert `rst` after 3 samples.
  - All outputs return to reset values.
  - The next 4 samples form a clean frame.
- **Extremes:** `s_valid` random at 50% and `out_ready` random at 50%, with samples -128 and 127.
  - Every frame matches the reference queue bit-exactly.
  - No loss or duplication.

Source files
------------

// File: rtl/fft4_pkg.sv
// fft4_pkg
// Shared definitions for the 4-point FFT datapath: frame length, index width,
// default widths and the complex sample type used by fft4 and later stages.
// No ports; imported with "import fft4_pkg::*;".

package fft4_pkg;

  localparam int FRAME_LEN          = 4;
  localparam int IDX_WIDTH          = $clog2(FRAME_LEN);
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 8;

  // "real" is a keyword, hence re/im.
  typedef struct packed {
    logic signed [DEFAULT_DATA_WIDTH-1:0] re;
    logic signed [DEFAULT_DATA_WIDTH-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft4_frame_bank.sv
// fft4_frame_bank
// One ping-pong bank of the frame loader: FRAME_LEN complex sample registers
// plus a full flag.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_wr_en, i_wr_idx       write one sample into slot i_wr_idx
//   i_wr_real, i_wr_imag    sample being written
//   i_set_full, i_clr_full  mark the bank full (frame complete) / empty (drained)
//   o_full                  bank holds a complete frame
//   o_real, o_imag          register contents, slot 0 = first sample of frame

module fft4_frame_bank
  import fft4_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr_en,
  input  logic [IDX_WIDTH-1:0]         i_wr_idx,
  input  logic signed [DATA_WIDTH-1:0] i_wr_real,
  input  logic signed [DATA_WIDTH-1:0] i_wr_imag,
  input  logic                         i_set_full,
  input  logic                         i_clr_full,
  output logic                         o_full,
  output logic signed [DATA_WIDTH-1:0] o_real [FRAME_LEN],
  output logic signed [DATA_WIDTH-1:0] o_imag [FRAME_LEN]
);

  logic signed [DATA_WIDTH-1:0] r_real [FRAME_LEN];
  logic signed [DATA_WIDTH-1:0] r_imag [FRAME_LEN];
  logic                         r_full;

  // The top never sets and clears the same bank in one cycle; set wins
  // anyway so a completed frame can never be lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        r_real[k] <= '0;
        r_imag[k] <= '0;
      end
      r_full <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_real[i_wr_idx] <= i_wr_real;
        r_imag[i_wr_idx] <= i_wr_imag;
      end
      if (i_set_full) begin
        r_full <= 1'b1;
      end else if (i_clr_full) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_real = r_real;
  assign o_imag = r_imag;

endmodule

// File: rtl/fft4_frame_loader.sv
// fft4_frame_loader
// Serial-to-parallel front end for fft4. Collects one complex sample per cycle
// into a two-bank ping-pong buffer and presents each complete 4-sample frame
// in parallel. A start-of-frame marker mid-frame discards the partial frame
// and restarts at slot 0, counting the drop.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_s_valid/o_s_ready          input sample handshake
//   i_s_real, i_s_imag, i_s_sof  input sample and frame-index-0 marker
//   o_out{0..3}_{real,imag}      frame samples in arrival order
//   o_out_valid/i_out_ready      frame handshake (fft4.en = valid & ready)
//   o_drop_pulse                 one cycle after a partial frame is discarded
//   o_drop_count                 saturating count of discarded partial frames

module fft4_frame_loader
  import fft4_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  input  logic signed [DATA_WIDTH-1:0] i_s_real,
  input  logic signed [DATA_WIDTH-1:0] i_s_imag,
  input  logic                         i_s_sof,
  output logic signed [DATA_WIDTH-1:0] o_out0_real,
  output logic signed [DATA_WIDTH-1:0] o_out1_real,
  output logic signed [DATA_WIDTH-1:0] o_out2_real,
  output logic signed [DATA_WIDTH-1:0] o_out3_real,
  output logic signed [DATA_WIDTH-1:0] o_out0_imag,
  output logic signed [DATA_WIDTH-1:0] o_out1_imag,
  output logic signed [DATA_WIDTH-1:0] o_out2_imag,
  output logic signed [DATA_WIDTH-1:0] o_out3_imag,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic                         o_drop_pulse,
  output logic [CNT_WIDTH-1:0]         o_drop_count
);

  logic [IDX_WIDTH-1:0] r_wr_idx;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic                 r_drop_pulse;
  logic [CNT_WIDTH-1:0] r_drop_count;

  logic                         w_full      [2];
  logic signed [DATA_WIDTH-1:0] w_bank_real [2][FRAME_LEN];
  logic signed [DATA_WIDTH-1:0] w_bank_imag [2][FRAME_LEN];

  logic                 w_accept;
  logic                 w_realign;
  logic                 w_complete;
  logic                 w_drain;
  logic [IDX_WIDTH-1:0] w_wr_slot;

  // Ready depends only on registered state, never on i_out_ready.
  assign o_s_ready   = !i_rst && !w_full[r_wr_bank];
  assign w_accept    = i_s_valid && o_s_ready;
  assign w_realign   = w_accept && i_s_sof && (r_wr_idx != '0);
  assign w_wr_slot   = w_realign ? '0 : r_wr_idx;
  // A realigned sample lands in slot 0, so it can never complete a frame.
  assign w_complete  = w_accept && !w_realign &&
                       (r_wr_idx == IDX_WIDTH'(FRAME_LEN - 1));
  assign o_out_valid = w_full[r_rd_bank];
  assign w_drain     = o_out_valid && i_out_ready;

  // The write bank and read bank only coincide when that bank is either
  // full (no write) or empty (no drain), so set and clear never collide.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft4_frame_bank #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr_en    (w_accept && (r_wr_bank == 1'(b))),
      .i_wr_idx   (w_wr_slot),
      .i_wr_real  (i_s_real),
      .i_wr_imag  (i_s_imag),
      .i_set_full (w_complete && (r_wr_bank == 1'(b))),
      .i_clr_full (w_drain && (r_rd_bank == 1'(b))),
      .o_full     (w_full[b]),
      .o_real     (w_bank_real[b]),
      .o_imag     (w_bank_imag[b])
    );
  end

  // Write pointer, read pointer and drop bookkeeping. Fill of one bank and
  // drain of the other are handled independently in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_idx     <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_drop_pulse <= w_realign;
      if (w_realign && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end
      if (w_accept) begin
        if (w_complete) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= w_wr_slot + IDX_WIDTH'(1);
        end
      end
      if (w_drain) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign o_drop_pulse = r_drop_pulse;
  assign o_drop_count = r_drop_count;

  assign o_out0_real = w_bank_real[r_rd_bank][0];
  assign o_out1_real = w_bank_real[r_rd_bank][1];
  assign o_out2_real = w_bank_real[r_rd_bank][2];
  assign o_out3_real = w_bank_real[r_rd_bank][3];
  assign o_out0_imag = w_bank_imag[r_rd_bank][0];
  assign o_out1_imag = w_bank_imag[r_rd_bank][1];
  assign o_out2_imag = w_bank_imag[r_rd_bank][2];
  assign o_out3_imag = w_bank_imag[r_rd_bank][3];

endmodule

// File: tb/tb_fft4_frame_loader.sv
// tb_fft4_frame_loader
// Directed vector table for single frame / marker handling plus hand-written
// sequences for back-pressure, counter saturation, mid-frame reset and a
// randomised stream of extreme sample values against a reference queue.

module tb_fft4_frame_loader;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          sValid;
  logic          sReady;
  logic [DW-1:0] sReal;
  logic [DW-1:0] sImag;
  logic          sSof;
  logic [DW-1:0] outR [4];
  logic [DW-1:0] outI [4];
  logic          outValid;
  logic          outReady;
  logic          dropPulse;
  logic [CW-1:0] dropCount;

  int compared;
  int mismatched;

  typedef struct packed {
    logic          valid;
    logic          sof;
    logic [7:0]    re;
    logic [7:0]    im;
    logic          oready;
    logic          expSReady;
    logic          expOValid;
    logic          expDrop;
    logic [7:0]    expCount;
    logic [3:0][7:0] expR;
    logic [3:0][7:0] expI;
  } vec_t;

  fft4_frame_loader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_s_valid   (sValid),
    .o_s_ready   (sReady),
    .i_s_real    (sReal),
    .i_s_imag    (sImag),
    .i_s_sof     (sSof),
    .o_out0_real (outR[0]),
    .o_out1_real (outR[1]),
    .o_out2_real (outR[2]),
    .o_out3_real (outR[3]),
    .o_out0_imag (outI[0]),
    .o_out1_imag (outI[1]),
    .o_out2_imag (outI[2]),
    .o_out3_imag (outI[3]),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_drop_pulse(dropPulse),
    .o_drop_count(dropCount)
  );

  // 10-unit clock; inputs change and outputs are sampled around the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on the whole run so a stuck design still ends with a report.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d",
             compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0][7:0] frame(input logic [7:0] a, b, c, d);
    logic [3:0][7:0] f;
    f[0] = a;
    f[1] = b;
    f[2] = c;
    f[3] = d;
    return f;
  endfunction

  function automatic vec_t mkVec(input logic valid, sof, input logic [7:0] re, im,
                                 input logic oready, expS, expV, expD,
                                 input logic [7:0] expC,
                                 input logic [3:0][7:0] expR, expI);
    vec_t v;
    v.valid = valid; v.sof = sof; v.re = re; v.im = im; v.oready = oready;
    v.expSReady = expS; v.expOValid = expV; v.expDrop = expD; v.expCount = expC;
    v.expR = expR; v.expI = expI;
    return v;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic applyStimulus(input logic valid, sof, input logic [7:0] re, im,
                               input logic oready);
    @(negedge clk);
    sValid   = valid;
    sSof     = sof;
    sReal    = re;
    sImag    = im;
    outReady = oready;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkCore(input string tag, input logic expS, expV, expD,
                           input logic [7:0] expC);
    checkOutput({tag, " s_ready"}, 32'(sReady), 32'(expS));
    checkOutput({tag, " out_valid"}, 32'(outValid), 32'(expV));
    checkOutput({tag, " drop_pulse"}, 32'(dropPulse), 32'(expD));
    checkOutput({tag, " drop_count"}, 32'(dropCount), 32'(expC));
  endtask

  task automatic checkFrame(input string tag, input logic [3:0][7:0] er, ei);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s out%0d_real", tag, k), 32'(outR[k]), 32'(er[k]));
      checkOutput($sformatf("%s out%0d_imag", tag, k), 32'(outI[k]), 32'(ei[k]));
    end
  endtask

  // Assert reset mid-cycle, verify the reset values, release on the next falling edge.
  task automatic doReset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    sValid   = 1'b0;
    sSof     = 1'b0;
    sReal    = '0;
    sImag    = '0;
    outReady = 1'b0;
    #1;
    checkCore(tag, 1'b0, 1'b0, 1'b0, 8'd0);
    checkFrame(tag, frame(0, 0, 0, 0), frame(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t            vecs [16];
  logic [15:0]     refQ [$];
  logic [15:0]     item;
  logic [3:0][7:0] zero4;
  logic [3:0][7:0] fA;
  logic [3:0][7:0] fB;
  logic [3:0][7:0] fBi;
  int              nextSample;
  int              accepted;
  int              framesSeen;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    sValid     = 1'b0;
    sSof       = 1'b0;
    sReal      = '0;
    sImag      = '0;
    outReady   = 1'b0;
    zero4      = frame(0, 0, 0, 0);
    fA         = frame(8'd1, 8'd2, 8'hFF, 8'd3);
    fB         = frame(8'd7, 8'd8, 8'd9, 8'd10);
    fBi        = frame(8'hF9, 8'd8, 8'd9, 8'd10);

    // Single frame drained immediately, then a marker mid-frame, a held frame
    // and markers that must be ignored (no accept, or already at slot 0).
    vecs[0]  = mkVec(1, 0, 8'd1,  8'd0,  1, 1, 0, 0, 0, zero4, zero4);
    vecs[1]  = mkVec(1, 0, 8'd2,  8'd0,  1, 1, 0, 0, 0, zero4, zero4);
    vecs[2]  = mkVec(1, 0, 8'hFF, 8'd0,  1, 1, 0, 0, 0, zero4, zero4);
    vecs[3]  = mkVec(1, 0, 8'd3,  8'd0,  1, 1, 0, 0, 0, zero4, zero4);
    vecs[4]  = mkVec(0, 0, 8'd0,  8'd0,  1, 1, 1, 0, 0, fA, zero4);
    vecs[5]  = mkVec(0, 1, 8'd0,  8'd0,  0, 1, 0, 0, 0, zero4, zero4);
    vecs[6]  = mkVec(1, 1, 8'd5,  8'd5,  0, 1, 0, 0, 0, zero4, zero4);
    vecs[7]  = mkVec(1, 0, 8'd6,  8'd6,  0, 1, 0, 0, 0, zero4, zero4);
    vecs[8]  = mkVec(1, 1, 8'd7,  8'hF9, 0, 1, 0, 0, 0, zero4, zero4);
    vecs[9]  = mkVec(1, 0, 8'd8,  8'd8,  0, 1, 0, 1, 1, zero4, zero4);
    vecs[10] = mkVec(1, 0, 8'd9,  8'd9,  0, 1, 0, 0, 1, zero4, zero4);
    vecs[11] = mkVec(1, 0, 8'd10, 8'd10, 0, 1, 0, 0, 1, zero4, zero4);
    vecs[12] = mkVec(0, 0, 8'd0,  8'd0,  0, 1, 1, 0, 1, fB, fBi);
    vecs[13] = mkVec(0, 0, 8'd0,  8'd0,  0, 1, 1, 0, 1, fB, fBi);
    vecs[14] = mkVec(0, 0, 8'd0,  8'd0,  1, 1, 1, 0, 1, fB, fBi);
    vecs[15] = mkVec(0, 0, 8'd0,  8'd0,  0, 1, 0, 0, 1, zero4, zero4);

    doReset("reset");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].sof, vecs[i].re, vecs[i].im, vecs[i].oready);
      checkCore($sformatf("vec%0d", i), vecs[i].expSReady, vecs[i].expOValid,
                vecs[i].expDrop, vecs[i].expCount);
      if (vecs[i].expOValid) begin
        checkFrame($sformatf("vec%0d", i), vecs[i].expR, vecs[i].expI);
      end
    end

    // Back-pressure: 8 samples fill both banks, ready drops, drains free it.
    doReset("bp reset");
    nextSample = 1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1, 0, 8'(nextSample), 8'(-nextSample), 0);
      checkOutput($sformatf("bp c%0d s_ready", c), 32'(sReady), 32'(c < 8));
      if (sReady) nextSample++;
    end
    checkOutput("bp held out_valid", 32'(outValid), 32'd1);
    checkFrame("bp held", frame(1, 2, 3, 4), frame(-1, -2, -3, -4));
    applyStimulus(1, 0, 8'(nextSample), 8'(-nextSample), 1);
    checkCore("bp drain1", 1'b0, 1'b1, 1'b0, 8'd0);
    checkFrame("bp frame1", frame(1, 2, 3, 4), frame(-1, -2, -3, -4));
    applyStimulus(1, 0, 8'(nextSample), 8'(-nextSample), 1);
    checkCore("bp drain2", 1'b1, 1'b1, 1'b0, 8'd0);
    checkFrame("bp frame2", frame(5, 6, 7, 8), frame(-5, -6, -7, -8));
    for (int s = 10; s <= 12; s++) begin
      applyStimulus(1, 0, 8'(s), 8'(-s), 1);
      checkCore($sformatf("bp tail%0d", s), 1'b1, 1'b0, 1'b0, 8'd0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkCore("bp frame3 valid", 1'b1, 1'b1, 1'b0, 8'd0);
    checkFrame("bp frame3", frame(9, 10, 11, 12), frame(-9, -10, -11, -12));
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bp empty out_valid", 32'(outValid), 32'd0);

    // Saturation: one plain sample then 300 markers, each one a discard.
    doReset("sat reset");
    applyStimulus(1, 0, 8'd1, 8'd1, 1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, 8'(i), 8'd0, 1);
      if (i == 255) checkOutput("sat count at 255 drops", 32'(dropCount), 32'd255);
    end
    applyStimulus(1, 0, 8'd50, 8'd50, 1);
    checkCore("sat final", 1'b1, 1'b0, 1'b1, 8'd255);
    applyStimulus(1, 0, 8'd51, 8'd51, 1);
    checkCore("sat held", 1'b1, 1'b0, 1'b0, 8'd255);

    // Reset mid-frame: partial frame and counter cleared, next frame clean.
    doReset("midframe reset");
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1, 0, 8'(20 + s), 8'(-20 - s), 1);
      checkCore($sformatf("post reset s%0d", s), 1'b1, 1'b0, 1'b0, 8'd0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkCore("post reset frame", 1'b1, 1'b1, 1'b0, 8'd0);
    checkFrame("post reset frame", frame(20, 21, 22, 23), frame(-20, -21, -22, -23));

    // Random valid/ready with extreme values against a reference queue.
    doReset("rand reset");
    accepted   = 0;
    framesSeen = 0;
    refQ.delete();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        applyStimulus(1'($urandom_range(0, 1)), 0,
                      $urandom_range(0, 1) ? 8'h80 : 8'h7F,
                      $urandom_range(0, 1) ? 8'h80 : 8'h7F,
                      1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(0, 0, 0, 0, 1);
      end
      checkOutput("rand s_ready", 32'(sReady), 32'(refQ.size() < 8));
      checkOutput("rand out_valid", 32'(outValid), 32'(refQ.size() >= 4));
      if (outValid && outReady && refQ.size() >= 4) begin
        framesSeen++;
        for (int k = 0; k < 4; k++) begin
          item = refQ.pop_front();
          checkOutput($sformatf("rand f%0d out%0d_real", framesSeen, k), 32'(outR[k]), 32'(item[15:8]));
          checkOutput($sformatf("rand f%0d out%0d_imag", framesSeen, k), 32'(outI[k]), 32'(item[7:0]));
        end
      end
      if (sValid && sReady) begin
        refQ.push_back({sReal, sImag});
        accepted++;
      end
    end
    checkOutput("rand frames delivered", 32'(framesSeen), 32'(accepted / 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
